spi_flash_wb_reader: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 40 ++++
 rtl/wb_single_master.sv | 54 +++++
 rtl/spi_flash_wb_reader.sv | 195 +++++++++++++++++++
 tb/tb_spi_flash_wb_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash Wishbone reader.
// SPI_FLASH_FAST_READ_EN selects FAST_READ (0x0B + dummy byte) instead of READ (0x03).
package spi_flash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_OPEN,
    ST_CMD,
    ST_ADDR2,
    ST_ADDR1,
    ST_ADDR0,
    ST_DUMMY,
    ST_CFG_RX,
    ST_INJECT,
    ST_READ,
    ST_CLOSE,
    ST_DONE_IDLE
  } state_t;

  localparam logic [7:0] CFG_OFS  = 8'd1;
  localparam logic [7:0] DATA_OFS = 8'd2;
  localparam logic [7:0] INJ_OFS  = 8'd3;

  localparam logic [7:0] CFG_OPEN  = 8'h02;
  localparam logic [7:0] CFG_RX    = 8'h00;
  localparam logic [7:0] CFG_CLOSE = 8'h01;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] DUMMY_BYTE    = 8'h00;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST_READ = 1'b1;
`else
  localparam bit FAST_READ = 1'b0;
`endif

  localparam logic [7:0] READ_CMD = FAST_READ ? CMD_FAST_READ : CMD_READ;

endpackage

// File: rtl/wb_single_master.sv
// Single-outstanding Wishbone master: start launches one transaction,
// done pulses combinationally with ack, rdata is valid while done is high.
module wb_single_master (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] m_wb_addr,
  output logic [7:0] m_wb_dat_m2s,
  input  logic [7:0] m_wb_dat_s2m,
  output logic       m_wb_we,
  output logic       m_wb_sel,
  output logic       m_wb_stb,
  output logic       m_wb_cyc,
  input  logic       m_wb_ack,
  input  logic       m_wb_stall
);

  assign m_wb_sel = 1'b1;
  assign done     = m_wb_cyc && m_wb_ack;
  assign rdata    = m_wb_dat_s2m;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      m_wb_cyc     <= 1'b0;
      m_wb_stb     <= 1'b0;
      m_wb_we      <= 1'b0;
      m_wb_addr    <= 8'h00;
      m_wb_dat_m2s <= 8'h00;
    end else if (!m_wb_cyc) begin
      if (start) begin
        m_wb_cyc     <= 1'b1;
        m_wb_stb     <= 1'b1;
        m_wb_we      <= we;
        m_wb_addr    <= addr;
        m_wb_dat_m2s <= wdata;
      end
    end else begin
      // stb drops once the slave takes the request; cyc stays until ack
      if (m_wb_stb && !m_wb_stall)
        m_wb_stb <= 1'b0;
      if (m_wb_ack) begin
        m_wb_cyc <= 1'b0;
        m_wb_stb <= 1'b0;
        m_wb_we  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_flash_wb_reader.sv
// Sequences SPI NOR flash reads through the 3-register SPI master slave and
// streams the returned bytes out on AXI-stream. Option: SPI_FLASH_FAST_READ_EN.
//
// state        | meaning
// IDLE         | ready for a request
// CFG_OPEN     | SS low, discard RX
// CMD          | read opcode
// ADDR2..ADDR0 | flash address, MSB first
// DUMMY        | fast-read dummy byte
// CFG_RX       | keep RX from here on
// INJECT       | queue min(remaining, CHUNK_MAX) dummy TX bytes
// READ         | pop RX bytes into the output register
// CLOSE        | SS high
// DONE_IDLE    | one cycle back to IDLE
module spi_flash_wb_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] WB_BASE   = 8'h00,
  parameter int         LEN_BITS  = 16,
  parameter int         CHUNK_MAX = 255
) (
  input  logic                clk,
  input  logic                sresetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [23:0]         req_addr,
  input  logic [LEN_BITS-1:0] req_len,
  output logic                busy,
  output logic [7:0]          m_wb_addr,
  output logic [7:0]          m_wb_dat_m2s,
  input  logic [7:0]          m_wb_dat_s2m,
  output logic                m_wb_we,
  output logic                m_wb_sel,
  output logic                m_wb_stb,
  output logic                m_wb_cyc,
  input  logic                m_wb_ack,
  input  logic                m_wb_stall,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tlast
);

  state_t              state, next_st;
  logic [23:0]         addr_q;
  logic [LEN_BITS-1:0] remaining;
  logic [7:0]          chunk, chunk_calc;
  logic                issued;
  logic                wb_start, wb_we;
  logic [7:0]          wb_addr, wb_wdata;
  logic                wb_done;
  logic [7:0]          wb_rdata;
  logic [7:0]          op_addr, op_data;
  logic                op_we;
  logic                out_free;

  wb_single_master u_wb (
    .clk          (clk),
    .sresetn      (sresetn),
    .start        (wb_start),
    .addr         (wb_addr),
    .wdata        (wb_wdata),
    .we           (wb_we),
    .done         (wb_done),
    .rdata        (wb_rdata),
    .m_wb_addr    (m_wb_addr),
    .m_wb_dat_m2s (m_wb_dat_m2s),
    .m_wb_dat_s2m (m_wb_dat_s2m),
    .m_wb_we      (m_wb_we),
    .m_wb_sel     (m_wb_sel),
    .m_wb_stb     (m_wb_stb),
    .m_wb_cyc     (m_wb_cyc),
    .m_wb_ack     (m_wb_ack),
    .m_wb_stall   (m_wb_stall)
  );

  assign out_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    if (remaining > LEN_BITS'(CHUNK_MAX))
      chunk_calc = 8'(CHUNK_MAX);
    else
      chunk_calc = remaining[7:0];
  end

  // Register access performed by each sequencing state and its successor
  always_comb begin
    op_addr = WB_BASE + CFG_OFS;
    op_data = 8'h00;
    op_we   = 1'b1;
    next_st = state;
    case (state)
      ST_CFG_OPEN: begin op_data = CFG_OPEN; next_st = ST_CMD; end
      ST_CMD:      begin op_addr = WB_BASE + DATA_OFS; op_data = READ_CMD; next_st = ST_ADDR2; end
      ST_ADDR2:    begin op_addr = WB_BASE + DATA_OFS; op_data = addr_q[23:16]; next_st = ST_ADDR1; end
      ST_ADDR1:    begin op_addr = WB_BASE + DATA_OFS; op_data = addr_q[15:8]; next_st = ST_ADDR0; end
      ST_ADDR0: begin
        op_addr = WB_BASE + DATA_OFS;
        op_data = addr_q[7:0];
        next_st = FAST_READ ? ST_DUMMY : ST_CFG_RX;
      end
      ST_DUMMY:    begin op_addr = WB_BASE + DATA_OFS; op_data = DUMMY_BYTE; next_st = ST_CFG_RX; end
      ST_CFG_RX:   begin op_data = CFG_RX; next_st = ST_INJECT; end
      ST_INJECT:   begin op_addr = WB_BASE + INJ_OFS; op_data = chunk_calc; next_st = ST_READ; end
      ST_READ:     begin op_addr = WB_BASE + DATA_OFS; op_we = 1'b0; end
      ST_CLOSE:    begin op_data = CFG_CLOSE; next_st = ST_DONE_IDLE; end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      addr_q        <= 24'h0;
      remaining     <= '0;
      chunk         <= 8'h00;
      issued        <= 1'b0;
      wb_start      <= 1'b0;
      wb_addr       <= 8'h00;
      wb_wdata      <= 8'h00;
      wb_we         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= 8'h00;
    end else begin
      wb_start <= 1'b0;

      if (wb_done && state == ST_READ) begin
        m_axis_tdata  <= wb_rdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (remaining == LEN_BITS'(1));
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            addr_q    <= req_addr;
            remaining <= req_len;
            state     <= (req_len == '0) ? ST_DONE_IDLE : ST_CFG_OPEN;
          end
        end
        ST_DONE_IDLE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_READ: begin
          if (issued) begin
            if (wb_done) begin
              issued    <= 1'b0;
              remaining <= remaining - LEN_BITS'(1);
              chunk     <= chunk - 8'd1;
            end
          end else if (remaining == '0) begin
            if (out_free)
              state <= ST_CLOSE;
          end else if (chunk == 8'h00) begin
            state <= ST_INJECT;
          end else if (out_free) begin
            // only one byte of buffering, so a read waits for the slot to drain
            wb_start <= 1'b1;
            wb_addr  <= op_addr;
            wb_wdata <= op_data;
            wb_we    <= op_we;
            issued   <= 1'b1;
          end
        end
        default: begin
          if (!issued) begin
            wb_start <= 1'b1;
            wb_addr  <= op_addr;
            wb_wdata <= op_data;
            wb_we    <= op_we;
            issued   <= 1'b1;
          end else if (wb_done) begin
            issued <= 1'b0;
            state  <= next_st;
            if (state == ST_INJECT)
              chunk <= chunk_calc;
            if (state == ST_CLOSE)
              busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
// Bench for spi_flash_wb_reader: behavioural SPI master slave + flash model,
// stream checked against flash(addr + i). Honours SPI_FLASH_FAST_READ_EN.
module tb_spi_flash_wb_reader;

  localparam logic [7:0] BASE = 8'h00;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int         HDR = FAST ? 5 : 4;
  localparam logic [7:0] OPC = FAST ? 8'h0B : 8'h03;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        busy;
  logic [7:0]  m_wb_addr, m_wb_dat_m2s, m_wb_dat_s2m;
  logic        m_wb_we, m_wb_sel, m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_stall;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tdata;

  always #5 clk = ~clk;

  spi_flash_wb_reader dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .busy          (busy),
    .m_wb_addr     (m_wb_addr),
    .m_wb_dat_m2s  (m_wb_dat_m2s),
    .m_wb_dat_s2m  (m_wb_dat_s2m),
    .m_wb_we       (m_wb_we),
    .m_wb_sel      (m_wb_sel),
    .m_wb_stb      (m_wb_stb),
    .m_wb_cyc      (m_wb_cyc),
    .m_wb_ack      (m_wb_ack),
    .m_wb_stall    (m_wb_stall),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct {
    bit         we;
    logic [7:0] a;
    logic [7:0] d;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  bit          rnd_mode = 1'b0;
  txn_t        wlog[$];
  logic [8:0]  beats[$];
  int          cyc_cnt = 0;
  int          busy_cnt = 0;
  int          underflow = 0;

  // slave model state
  bit          ss = 1'b1;
  bit          discard = 1'b0;
  int          idx = 0;
  logic [7:0]  cmd;
  logic [23:0] fa;
  logic [7:0]  fifo[$];
  bit          pend = 1'b0;
  int          dly = 0;
  logic [7:0]  rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash(input logic [23:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
  endfunction

  task automatic shift_byte(input logic [7:0] tx);
    logic [7:0] miso;
    if (!ss) begin
      if (idx == 0) cmd = tx;
      else if (idx <= 3) fa = {fa[15:0], tx};
      miso = (idx >= HDR && cmd == OPC) ? flash(fa + 24'(idx - HDR)) : 8'hA5;
      idx++;
      if (!discard) fifo.push_back(miso);
    end
  endtask

  task automatic do_txn();
    txn_t t;
    t.we = m_wb_we;
    t.a  = m_wb_addr;
    rd   = 8'h00;
    if (m_wb_we) begin
      if (m_wb_addr == BASE + 8'd1) begin
        if (ss && !m_wb_dat_m2s[0]) begin idx = 0; fifo.delete(); end
        ss      = m_wb_dat_m2s[0];
        discard = m_wb_dat_m2s[1];
      end else if (m_wb_addr == BASE + 8'd2) begin
        shift_byte(m_wb_dat_m2s);
      end else if (m_wb_addr == BASE + 8'd3) begin
        repeat (int'(m_wb_dat_m2s)) shift_byte(8'h00);
      end
      t.d = m_wb_dat_m2s;
    end else begin
      if (m_wb_addr == BASE + 8'd2) begin
        if (fifo.size() > 0) rd = fifo.pop_front();
        else begin underflow++; rd = 8'hEE; end
      end
      t.d = rd;
    end
    wlog.push_back(t);
  endtask

  // Wishbone slave + tready driver
  initial begin
    m_wb_ack = 1'b0; m_wb_stall = 1'b0; m_wb_dat_s2m = 8'h00; m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_wb_ack = 1'b0;
      m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!sresetn) begin
        ss = 1'b1; discard = 1'b0; idx = 0; fifo.delete(); pend = 1'b0; m_wb_stall = 1'b0;
      end else if (!m_wb_cyc) begin
        pend = 1'b0; m_wb_stall = 1'b0;
      end else if (pend) begin
        m_wb_stall = 1'b0;
        chk("single_outstanding", {31'd0, m_wb_stb}, 32'd0);
        if (dly == 0) begin m_wb_ack = 1'b1; m_wb_dat_s2m = rd; pend = 1'b0; end
        else dly--;
      end else if (m_wb_stb) begin
        m_wb_stall = rnd_mode && ($urandom_range(0, 2) == 0);
        if (!m_wb_stall) begin
          do_txn();
          pend = 1'b1;
          dly  = rnd_mode ? int'($urandom_range(0, 3)) : 0;
        end
      end else begin
        m_wb_stall = 1'b0;
      end
    end
  end

  // stream capture, hold-stability and activity counters
  initial begin
    bit         prev_hold = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;
    forever begin
      @(negedge clk);
      if (sresetn && prev_hold)
        chk("tdata_stable", {22'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {22'd0, 1'b1, prev_l, prev_d});
      prev_hold = sresetn && m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (sresetn && m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
      if (m_wb_cyc) cyc_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic do_req(input logic [23:0] a, input int len);
    int n = 0;
    beats.delete(); wlog.delete(); busy_cnt = 0; cyc_cnt = 0;
    req_addr = a; req_len = 16'(len); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while ((busy || !req_ready) && n < 20000) begin @(posedge clk); #1; n++; end
    chk("req_timeout", {31'd0, n < 20000}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [23:0] a, input int len);
    int bad = 0;
    chk({tag, " beats"}, beats.size(), len);
    foreach (beats[i])
      if (beats[i] !== {(i == len - 1), flash(a + 24'(i))}) bad++;
    chk({tag, " data_tlast"}, bad, 0);
    chk({tag, " underflow"}, underflow, 0);
  endtask

  function automatic int count_reads();
    int c = 0;
    foreach (wlog[i]) if (!wlog[i].we) c++;
    return c;
  endfunction

  initial begin
    txn_t exp[$];
    int   bad;
    int   inj[$];
    int   n;
    logic [23:0] a;
    int   len;

    sresetn = 1'b0; req_valid = 1'b0; req_addr = 24'h0; req_len = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst cyc_stb_we", {29'd0, m_wb_cyc, m_wb_stb, m_wb_we}, 32'd0);
    chk("rst wb_addr_dat", {16'd0, m_wb_addr, m_wb_dat_m2s}, 32'd0);
    chk("rst tvalid_tlast", {30'd0, m_axis_tvalid, m_axis_tlast}, 32'd0);
    chk("wb_sel", {31'd0, m_wb_sel}, 32'd1);
    sresetn = 1'b1;
    @(posedge clk); #1;

    // basic 4-byte read
    do_req(24'h123456, 4);
    check_stream("t1", 24'h123456, 4);
    exp = {};
    exp.push_back('{1'b1, BASE + 8'd1, 8'h02});
    exp.push_back('{1'b1, BASE + 8'd2, OPC});
    exp.push_back('{1'b1, BASE + 8'd2, 8'h12});
    exp.push_back('{1'b1, BASE + 8'd2, 8'h34});
    exp.push_back('{1'b1, BASE + 8'd2, 8'h56});
    if (FAST) exp.push_back('{1'b1, BASE + 8'd2, 8'h00});
    exp.push_back('{1'b1, BASE + 8'd1, 8'h00});
    exp.push_back('{1'b1, BASE + 8'd3, 8'h04});
    for (int i = 0; i < 4; i++) exp.push_back('{1'b0, BASE + 8'd2, flash(24'h123456 + 24'(i))});
    exp.push_back('{1'b1, BASE + 8'd1, 8'h01});
    chk("t1 log_size", wlog.size(), exp.size());
    bad = 0;
    foreach (exp[i])
      if (i >= wlog.size() || wlog[i].we !== exp[i].we || wlog[i].a !== exp[i].a || wlog[i].d !== exp[i].d) bad++;
    chk("t1 log_content", bad, 0);
    chk("t1 busy_low", {30'd0, busy, req_ready}, 32'd1);

    // zero length
    do_req(24'hABCDEF, 0);
    chk("len0 no_cyc", cyc_cnt, 0);
    chk("len0 busy_pulse", {31'd0, busy_cnt >= 1 && busy_cnt <= 2}, 32'd1);
    chk("len0 beats", beats.size(), 0);
    chk("len0 req_ready", {31'd0, req_ready}, 32'd1);

    // multi-chunk
    do_req(24'hFFFF80, 300);
    check_stream("len300", 24'hFFFF80, 300);
    inj = {};
    foreach (wlog[i]) if (wlog[i].we && wlog[i].a == BASE + 8'd3) inj.push_back(int'(wlog[i].d));
    chk("len300 inj_count", inj.size(), 2);
    chk("len300 inj0", inj.size() > 0 ? inj[0] : -1, 255);
    chk("len300 inj1", inj.size() > 1 ? inj[1] : -1, 45);

    // random stall / ack delay / tready
    rnd_mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom);
      len = int'($urandom_range(1, 40));
      do_req(a, len);
      check_stream("rand", a, len);
    end
    a = 24'($urandom);
    do_req(a, 270);
    check_stream("rand270", a, 270);
    rnd_mode = 1'b0;

    // reset in the middle of READ
    beats.delete(); wlog.delete();
    req_addr = 24'h000100; req_len = 16'd60; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (count_reads() < 3 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("midrst reach_read", {31'd0, n < 2000}, 32'd1);
    sresetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst cyc_stb", {30'd0, m_wb_cyc, m_wb_stb}, 32'd0);
    chk("midrst tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    sresetn = 1'b1;
    @(posedge clk); #1;
    do_req(24'h0A0B0C, 10);
    check_stream("after_rst", 24'h0A0B0C, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
